// File: rtl/imem_boot_sequencer_pkg.sv
// imem_boot_pkg
// Shared definitions for the instruction-memory boot sequencer:
//   - boot_state_e : FSM state encoding (IDLE=0, CLEAR=1, LOAD=2, SETTLE=3, RUN=4)
//   - DELAY_W      : width of the clear/settle delay counter
//   - len_is_valid : load-length validation helper
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } boot_state_e;

  localparam int DELAY_W = 8;

  // A load must contain at least one word and must fit between the start
  // address and the top of memory, so write addresses can never wrap.
  function automatic logic len_is_valid(input int unsigned len,
                                        input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/imem_boot_sequencer_delay.sv
// boot_delay_counter
// Loadable down-counter used to time the memory-clear pulse and the
// post-load settle window.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-low reset
//   load       : load load_value into the counter
//   load_value : value to load (cycles remaining minus one)
//   dec        : decrement by one (ignored while load is high)
//   zero       : counter currently holds zero
module boot_delay_counter
  import imem_boot_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [DELAY_W-1:0] count_q;
  logic [DELAY_W-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - DELAY_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer
// Loads a program from a valid/ready host stream into the instruction memory
// and sequences the core reset around the load: clear memory, write words to
// consecutive addresses, hold reset for a settle window, then release.
// Ports:
//   clock, reset            : clock and synchronous active-low reset
//   load_req, load_len      : request a (re)load of load_len words
//   load_abort              : abort a load in progress (CLEAR/LOAD)
//   s_valid, s_data, s_ready: host word stream
//   imem_clear              : instruction-memory clear pulse
//   imem_we/addr/wdata      : instruction-memory write port
//   core_reset              : active-high pipeline reset
//   busy, done, error       : status (error is sticky until a valid load)
module imem_boot_sequencer
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int START_ADDR    = 0,
  parameter int CLEAR_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned MAX_LEN = (1 << ADDR_W) - START_ADDR;

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   counter_q, counter_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic [ADDR_W:0]   counter_inc;
  logic              error_q, error_d;
  logic              imem_clear_q, imem_clear_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic               dly_load;
  logic [DELAY_W-1:0] dly_value;
  logic               dly_dec;
  logic               dly_zero;

  boot_delay_counter u_delay (
    .clock      (clock),
    .reset      (reset),
    .load       (dly_load),
    .load_value (dly_value),
    .dec        (dly_dec),
    .zero       (dly_zero)
  );

  assign counter_inc = counter_q + (ADDR_W+1)'(1);

  // Next-state logic. Every registered output is derived from the next
  // state (or the transfer in flight) so it changes on the same edge as
  // the state itself. The delay counter is loaded with N-1 on entry so the
  // state lasts exactly N cycles.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    length_d     = length_q;
    error_d      = error_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dly_load     = 1'b0;
    dly_value    = '0;
    dly_dec      = 1'b0;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_req) begin
          if (len_is_valid(32'(load_len), MAX_LEN)) begin
            error_d   = 1'b0;
            length_d  = load_len;
            counter_d = '0;
            state_d   = ST_CLEAR;
            dly_load  = 1'b1;
            dly_value = DELAY_W'(CLEAR_CYCLES - 1);
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        if (load_abort) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (dly_zero) begin
          state_d = ST_LOAD;
        end else begin
          dly_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        // Abort wins over a transfer in the same cycle; that word is dropped.
        if (load_abort) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (s_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ADDR_W'(START_ADDR + int'(counter_q));
          imem_wdata_d = s_data;
          counter_d    = counter_inc;
          if (counter_inc == length_q) begin
            state_d   = ST_SETTLE;
            dly_load  = 1'b1;
            dly_value = DELAY_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      ST_SETTLE: begin
        if (dly_zero) begin
          state_d = ST_RUN;
        end else begin
          dly_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    imem_clear_d = (state_d == ST_CLEAR);
    core_reset_d = (state_d != ST_RUN);
    done_d       = (state_d == ST_RUN);
    busy_d       = (state_d == ST_CLEAR) || (state_d == ST_LOAD) ||
                   (state_d == ST_SETTLE);
  end

  // State and registered outputs; reset parks the core in reset with all
  // other outputs low. Memory contents are not touched by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      length_q     <= '0;
      error_q      <= 1'b0;
      imem_clear_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      length_q     <= length_d;
      error_q      <= error_d;
      imem_clear_q <= imem_clear_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign imem_clear = imem_clear_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb_imem_boot_sequencer
// Directed bench for imem_boot_sequencer. Expected writes are pushed into a
// queue when a word is handed to the DUT; a negedge monitor pops and
// compares every write strobe the DUT produces.
module tb_imem_boot_sequencer;

  logic        clock;
  logic        reset;
  logic        load_req;
  logic [10:0] load_len;
  logic        load_abort;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        imem_clear;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          clear_count = 0;
  int          we_count    = 0;
  logic [31:0] words[0:7];

  imem_boot_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .load_req   (load_req),
    .load_len   (load_len),
    .load_abort (load_abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_clear (imem_clear),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point; every check funnels through here.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (reset) begin
      if (imem_clear) clear_count++;
      if (imem_we) begin
        we_count++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check_output("write_addr", 32'(imem_addr), 32'(e.addr));
          check_output("write_data", imem_wdata, e.data);
        end
      end
    end
  end

  task automatic request_load(input logic [10:0] len);
    load_req = 1'b1;
    load_len = len;
    tick();
    load_req = 1'b0;
  endtask

  // Streams n words (optionally with s_valid on every other cycle), then
  // offers one extra word that must be ignored, then checks the release.
  task automatic apply_stimulus(input int n, input bit toggle);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 200) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = words[sent];
      if (s_valid && s_ready) begin
        exp_q.push_back('{addr: 10'(sent), data: words[sent]});
        sent++;
      end
      tick();
      cyc++;
    end
    check_output("stream_words_sent", 32'(sent), 32'(n));
    check_output("ready_after_last", 32'(s_ready), 32'd0);
    check_output("reset_at_last_write", 32'(core_reset), 32'd1);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    tick();
    s_valid = 1'b0;
    check_output("reset_held_settle", 32'(core_reset), 32'd1);
    check_output("done_low_settle", 32'(done), 32'd0);
    tick();
    check_output("reset_released", 32'(core_reset), 32'd0);
    check_output("done_in_run", 32'(done), 32'd1);
    check_output("busy_in_run", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int w0;
    words[0] = 32'h0010_2083;
    words[1] = 32'h0025_0183;
    words[2] = 32'h0030_8333;
    words[3] = 32'h1111_0001;
    words[4] = 32'h2222_0002;
    words[5] = 32'h3333_0003;
    words[6] = 32'h4444_0004;
    words[7] = 32'h5555_0005;

    reset      = 1'b0;
    load_req   = 1'b0;
    load_len   = '0;
    load_abort = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;

    // Reset held for three cycles.
    repeat (3) tick();
    check_output("rst_core_reset", 32'(core_reset), 32'd1);
    check_output("rst_outputs", {25'd0, imem_clear, imem_we, busy, done, error, s_ready, 1'b0}, 32'd0);
    check_output("rst_addr", 32'(imem_addr), 32'd0);
    check_output("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b1;
    tick();
    check_output("idle_core_reset", 32'(core_reset), 32'd1);
    check_output("idle_busy", 32'(busy), 32'd0);

    // Three-word back-to-back load.
    c0 = clear_count;
    w0 = we_count;
    request_load(11'd3);
    check_output("clear_pulse", 32'(imem_clear), 32'd1);
    check_output("clear_busy", 32'(busy), 32'd1);
    apply_stimulus(3, 1'b0);
    check_output("load3_clear_cycles", 32'(clear_count - c0), 32'd1);
    check_output("load3_writes", 32'(we_count - w0), 32'd3);

    // Invalid lengths: zero (from RUN), then one past the top of memory.
    c0 = clear_count;
    w0 = we_count;
    request_load(11'd0);
    check_output("len0_error", 32'(error), 32'd1);
    check_output("len0_core_reset", 32'(core_reset), 32'd1);
    check_output("len0_done", 32'(done), 32'd0);
    tick();
    request_load(11'd1025);
    check_output("len1025_error", 32'(error), 32'd1);
    check_output("len1025_busy", 32'(busy), 32'd0);
    tick();
    check_output("invalid_no_clear", 32'(clear_count - c0), 32'd0);
    check_output("invalid_no_write", 32'(we_count - w0), 32'd0);

    // Four words with s_valid toggling; a valid load clears the error.
    w0 = we_count;
    request_load(11'd4);
    check_output("load4_error_cleared", 32'(error), 32'd0);
    apply_stimulus(4, 1'b1);
    check_output("load4_writes", 32'(we_count - w0), 32'd4);

    // Abort on the second beat of a five-word load.
    w0 = we_count;
    request_load(11'd5);
    tick();
    check_output("abort_in_load", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = words[0];
    exp_q.push_back('{addr: 10'd0, data: words[0]});
    tick();
    s_data     = words[1];
    load_abort = 1'b1;
    tick();
    s_valid    = 1'b0;
    load_abort = 1'b0;
    check_output("abort_error", 32'(error), 32'd1);
    check_output("abort_core_reset", 32'(core_reset), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_we", 32'(imem_we), 32'd0);
    tick();
    check_output("abort_writes", 32'(we_count - w0), 32'd1);

    // Get back to RUN with one word, then reload two words from RUN.
    request_load(11'd1);
    apply_stimulus(1, 1'b0);
    c0 = clear_count;
    w0 = we_count;
    request_load(11'd2);
    check_output("reload_core_reset", 32'(core_reset), 32'd1);
    check_output("reload_done", 32'(done), 32'd0);
    check_output("reload_clear", 32'(imem_clear), 32'd1);
    apply_stimulus(2, 1'b0);
    check_output("reload_clear_cycles", 32'(clear_count - c0), 32'd1);
    check_output("reload_writes", 32'(we_count - w0), 32'd2);

    repeat (3) tick();
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
Controller that loads a program into the pipeline's instruction memory and sequences the core's reset around the load. It accepts instruction words from a host stream using a valid/ready handshake. It clears the instruction memory, writes the words to consecutive addresses, holds the pipeline in reset for a settle window, then releases it. The block sits between the host/debug port and the TOP-level instruction-memory write port (PC_write, instruction_in, reset_IF_memory) and the core reset.

Parameters:
ADDR_W, 10, instruction-memory address width (word addressed)
DATA_W, 32, instruction word width
START_ADDR, 0, first address written by a load
CLEAR_CYCLES, 1, cycles imem_clear is held high
SETTLE_CYCLES, 2, cycles core_reset is held after the last write before release

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
load_req  in  1  request a (re)load; sampled in IDLE and RUN only
load_len  in  ADDR_W+1  number of words to load, captured with load_req
load_abort  in  1  abort an in-progress load
s_valid  in  1  host word valid
s_data  in  DATA_W  host instruction word
s_ready  out  1  block accepts a word this cycle
imem_clear  out  1  instruction-memory clear (drives reset_IF_memory)
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write address (drives PC_write)
imem_wdata  out  DATA_W  write data (drives instruction_in)
core_reset  out  1  active-high pipeline reset
busy  out  1  high in CLEAR, LOAD and SETTLE
done  out  1  high in RUN
error  out  1  sticky load error

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; core_reset=1.
  - All other outputs are 0, as are the word counter and the captured length.
- States: IDLE, CLEAR, LOAD, SETTLE, RUN. All outputs are registered except s_ready, which is (state==LOAD).
- IDLE:
  - core_reset=1.
  - On load_req=1, validate load_len.
  - Invalid if load_len==0 or load_len > 2^ADDR_W - START_ADDR: set error=1 and stay in IDLE.
  - Valid: clear error, capture the length, counter=0, go to CLEAR.
- CLEAR:
  - imem_clear=1 for exactly CLEAR_CYCLES cycles, then LOAD.
  - imem_clear returns to 0 on entry to LOAD.
- LOAD:
  - Handshake: a word transfers on a cycle where s_valid and s_ready are both high.
  - The cycle after a transfer: imem_we=1, imem_addr=START_ADDR+counter (pre-increment value), imem_wdata=s_data. counter increments.
  - imem_we is a single-cycle pulse per word. Back-to-back transfers produce consecutive write pulses.
  - When the transfer makes counter==length, the next state is SETTLE, so s_ready is low the cycle after the last beat.
  - s_valid while s_ready=0 is ignored (no overflow write).
  - Addresses never wrap: the length check guarantees the last address is ≤ 2^ADDR_W-1.
- SETTLE:
  - core_reset=1, imem_we=0.
  - Hold SETTLE_CYCLES cycles, then RUN.
- RUN:
  - core_reset=0 and done=1 from the first RUN cycle.
  - load_req=1 re-enters the IDLE validation path in the same cycle:
    - valid length: core_reset=1 and done=0 on the next cycle, go to CLEAR;
    - invalid length: error=1, go to IDLE, core_reset=1.
- load_req in CLEAR, LOAD or SETTLE is ignored.
- load_abort:
  - In CLEAR or LOAD: go to IDLE, error=1, imem_we=0 next cycle. A transfer in the same cycle is discarded.
  - Ignored in other states.
- Simultaneous load_abort and completing transfer: abort wins.
- Reset mid-load: immediate return to reset values. The memory contents are left as is.

Decomposition:
- Shared package (imem_boot_pkg): state encoding constants IDLE=0, CLEAR=1, LOAD=2, SETTLE=3, RUN=4.
- One natural sub-module: boot_delay_counter, a loadable down-counter reused for CLEAR_CYCLES and SETTLE_CYCLES.

Test Plan:
- Reset held low 3 cycles, then released -> core_reset=1, all other outputs 0, state IDLE.
- load_req with load_len=3; host sends 0x00102083, 0x00250183, 0x00308333 back-to-back:
  - imem_clear high 1 cycle;
  - writes at addr 0,1,2 with those words on three consecutive cycles;
  - core_reset falls 2 cycles after the last write; done=1.
- load_len=0, then a separate load_req with load_len=1025 -> error=1 both times, state stays IDLE, no imem_clear or imem_we.
- load_len=4 with s_valid toggling every other cycle -> exactly 4 write pulses at addr 0..3. Extra s_valid after the 4th beat produces no write.
- load_abort asserted during the 2nd beat of a 5-word load -> one write only (addr 0), error=1, IDLE, core_reset stays 1.
- In RUN, load_req with load_len=2 -> core_reset=1 and done=0 next cycle, clear pulse, 2 writes, release again.
